// File: rtl/gray_cnt_gen.sv
// gray_cnt_gen: registered binary/Gray count generator with valid/ready handshake.
// Steps up or down one count per accepted handshake, supports parallel load,
// stop to IDLE, and a one-cycle wrap pulse.
//
// Optional feature macro: GRAY_CNT_CHECK_EN
//   defined   -> each step is checked for a single-bit Gray change; o_err is sticky
//   undefined -> no check logic; o_err is tied low
//
// Ports:
//   i_clk, i_rstn          clock, asynchronous active-low reset
//   i_load, i_load_val     load request and binary value to load (enters RUN)
//   i_stop                 return to IDLE, count retained
//   i_en, i_up             step enable and direction (1 = increment)
//   i_ready                downstream accepts current sample
//   o_valid, o_bin, o_gray registered sample (binary and matching Gray code)
//   o_wrap                 one-cycle pulse after a modulo wrap step
//   o_err                  sticky step-check error
module gray_cnt_gen #(
    parameter int unsigned NBIT = 8
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_load,
    input  logic [NBIT-1:0] i_load_val,
    input  logic            i_stop,
    input  logic            i_en,
    input  logic            i_up,
    input  logic            i_ready,
    output logic            o_valid,
    output logic [NBIT-1:0] o_bin,
    output logic [NBIT-1:0] o_gray,
    output logic            o_wrap,
    output logic            o_err
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [NBIT-1:0] bin_q, bin_d;
    logic [NBIT-1:0] gray_q, gray_d;
    logic            valid_q, valid_d;
    logic            wrap_q, wrap_d;

    logic            step_c;
    logic [NBIT-1:0] bin_step_c;
    logic            wrap_hit_c;

    function automatic logic [NBIT-1:0] to_gray(input logic [NBIT-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // A step is one accepted handshake while running.
    assign step_c     = (state_q == ST_RUN) && valid_q && i_ready && i_en;
    assign bin_step_c = i_up ? (bin_q + NBIT'(1)) : (bin_q - NBIT'(1));
    assign wrap_hit_c = i_up ? (&bin_q) : (bin_q == '0);

`ifdef GRAY_CNT_CHECK_EN
    logic err_q, err_d;
    logic bad_step_c;

    // gray_q is the previous Gray output at the moment it is being replaced.
    assign bad_step_c = ($countones(gray_q ^ to_gray(bin_step_c)) != 1);
`endif

    // Next-state and next-output logic; priority is load > stop > step.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        gray_d  = gray_q;
        valid_d = valid_q;
        wrap_d  = 1'b0;
`ifdef GRAY_CNT_CHECK_EN
        err_d   = err_q;
`endif
        if (i_load) begin
            state_d = ST_RUN;
            bin_d   = i_load_val;
            gray_d  = to_gray(i_load_val);
            valid_d = 1'b1;
`ifdef GRAY_CNT_CHECK_EN
            err_d   = 1'b0;
`endif
        end else if (i_stop) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
        end else if (step_c) begin
            bin_d   = bin_step_c;
            gray_d  = to_gray(bin_step_c);
            wrap_d  = wrap_hit_c;
`ifdef GRAY_CNT_CHECK_EN
            err_d   = err_q | bad_step_c;
`endif
        end
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            gray_q  <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
`ifdef GRAY_CNT_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            gray_q  <= gray_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
`ifdef GRAY_CNT_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign o_valid = valid_q;
    assign o_bin   = bin_q;
    assign o_gray  = gray_q;
    assign o_wrap  = wrap_q;
`ifdef GRAY_CNT_CHECK_EN
    assign o_err   = err_q;
`else
    assign o_err   = 1'b0;
`endif

endmodule

// File: tb/tb_gray_cnt_gen.sv
// Directed bench for gray_cnt_gen (NBIT = 8) with hand-computed expectations.
module tb_gray_cnt_gen;

    localparam int unsigned NBIT = 8;

    logic            i_clk;
    logic            i_rstn;
    logic            i_load;
    logic [NBIT-1:0] i_load_val;
    logic            i_stop;
    logic            i_en;
    logic            i_up;
    logic            i_ready;
    logic            o_valid;
    logic [NBIT-1:0] o_bin;
    logic [NBIT-1:0] o_gray;
    logic            o_wrap;
    logic            o_err;

    int total = 0;
    int bad   = 0;

    gray_cnt_gen #(.NBIT(NBIT)) dut (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_load     (i_load),
        .i_load_val (i_load_val),
        .i_stop     (i_stop),
        .i_en       (i_en),
        .i_up       (i_up),
        .i_ready    (i_ready),
        .o_valid    (o_valid),
        .o_bin      (o_bin),
        .o_gray     (o_gray),
        .o_wrap     (o_wrap),
        .o_err      (o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] b, input logic [7:0] g,
                              input logic v, input logic w);
        check({tag, ".bin"},   32'(o_bin),   32'(b));
        check({tag, ".gray"},  32'(o_gray),  32'(g));
        check({tag, ".valid"}, 32'(o_valid), 32'(v));
        check({tag, ".wrap"},  32'(o_wrap),  32'(w));
        check({tag, ".err"},   32'(o_err),   32'd0);
    endtask

    logic [7:0] m_bin;
    logic [7:0] m_prev;
    logic       m_wrap;
    logic       dir;

    initial begin
        i_rstn = 1'b0; i_load = 1'b0; i_load_val = '0; i_stop = 1'b0;
        i_en = 1'b0; i_up = 1'b1; i_ready = 1'b0;

        // Reset held for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i % 5 == 0) expect_out("rst", 8'h00, 8'h00, 1'b0, 1'b0);
        end
        i_rstn = 1'b1;
        i_ready = 1'b1;
        // No load: i_en toggling must not move anything.
        for (int i = 0; i < 6; i++) begin
            i_en = ~i_en;
            tick();
            expect_out("idle", 8'h00, 8'h00, 1'b0, 1'b0);
        end

        // Load 0x7F and count up.
        i_load = 1'b1; i_load_val = 8'h7F; i_up = 1'b1; i_en = 1'b1; i_ready = 1'b1;
        tick();
        i_load = 1'b0;
        expect_out("ld7f", 8'h7F, 8'h40, 1'b1, 1'b0);
        tick();
        expect_out("inc1", 8'h80, 8'hC0, 1'b1, 1'b0);
        tick();
        expect_out("inc2", 8'h81, 8'hC1, 1'b1, 1'b0);

        // Down wrap from 0x01.
        i_load = 1'b1; i_load_val = 8'h01; i_up = 1'b0;
        tick();
        i_load = 1'b0;
        expect_out("ld01", 8'h01, 8'h01, 1'b1, 1'b0);
        tick();
        expect_out("dn00", 8'h00, 8'h00, 1'b1, 1'b0);
        tick();
        expect_out("dnff", 8'hFF, 8'h80, 1'b1, 1'b1);
        tick();
        expect_out("dnfe", 8'hFE, 8'h81, 1'b1, 1'b0);

        // Up wrap from 0xFF.
        i_load = 1'b1; i_load_val = 8'hFF; i_up = 1'b1;
        tick();
        i_load = 1'b0;
        expect_out("ldff", 8'hFF, 8'h80, 1'b1, 1'b0);
        tick();
        expect_out("up00", 8'h00, 8'h00, 1'b1, 1'b1);

        // Stall at 0x0A with i_ready low for 5 cycles.
        i_load = 1'b1; i_load_val = 8'h0A; i_ready = 1'b0;
        tick();
        i_load = 1'b0;
        expect_out("ld0a", 8'h0A, 8'h0F, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_out("stall", 8'h0A, 8'h0F, 1'b1, 1'b0);
        end
        i_ready = 1'b1;
        tick();
        expect_out("go0b", 8'h0B, 8'h0E, 1'b1, 1'b0);

        // Pause via i_en low.
        i_en = 1'b0;
        tick();
        expect_out("pause", 8'h0B, 8'h0E, 1'b1, 1'b0);
        i_en = 1'b1;

        // Load and stop together: load wins.
        i_load = 1'b1; i_stop = 1'b1; i_load_val = 8'h06;
        tick();
        i_load = 1'b0;
        expect_out("ldstp", 8'h06, 8'h05, 1'b1, 1'b0);
        tick();
        i_stop = 1'b0;
        expect_out("stop", 8'h06, 8'h05, 1'b0, 1'b0);
        tick();
        expect_out("idle2", 8'h06, 8'h05, 1'b0, 1'b0);

        // Random-direction stream of 200 steps against a count model.
        i_load = 1'b1; i_load_val = 8'h3C;
        m_bin = 8'h3C;
        tick();
        i_load = 1'b0;
        expect_out("ld3c", 8'h3C, 8'h22, 1'b1, 1'b0);
        for (int i = 0; i < 200; i++) begin
            dir = 1'($urandom_range(1, 0));
            i_up = dir;
            m_prev = m_bin;
            m_wrap = dir ? (m_bin == 8'hFF) : (m_bin == 8'h00);
            m_bin  = dir ? m_bin + 8'd1 : m_bin - 8'd1;
            tick();
            check("rnd.bin",  32'(o_bin),  32'(m_bin));
            check("rnd.gray", 32'(o_gray), 32'(m_bin ^ (m_bin >> 1)));
            check("rnd.wrap", 32'(o_wrap), 32'(m_wrap));
            check("rnd.err",  32'(o_err),  32'd0);
            check("rnd.1bit", 32'($countones(o_gray ^ (m_prev ^ (m_prev >> 1)))), 32'd1);
        end

        // Asynchronous reset mid-run: outputs clear before any clock edge.
        @(negedge i_clk);
        #2;
        i_rstn = 1'b0;
        #1;
        expect_out("arst", 8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        expect_out("arst2", 8'h00, 8'h00, 1'b0, 1'b0);
        i_rstn = 1'b1;
        tick();
        expect_out("post", 8'h00, 8'h00, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gray_cnt_gen.md
# gray_cnt_gen

Gray-code sequence generator that sits directly upstream of the binary-to-Gray / Gray-to-binary converter pair. It produces a registered binary count and its matching Gray code under a valid/ready handshake, so the converter chain receives legal single-bit-step stimulus. It supports up/down stepping, parallel load, stall, and a wrap indicator.

## Interface
- NBIT, 8, count width in bits (≥2)
- i_clk  input  1  clock; all state changes on rising edge
- i_rstn  input  1  reset, asynchronous, active-low
- i_load  input  1  load request; registers i_load_val, enters RUN
- i_load_val  input  NBIT  binary value loaded on i_load
- i_stop  input  1  returns FSM to IDLE; count retained
- i_en  input  1  step enable in RUN
- i_up  input  1  direction: 1 increments, 0 decrements
- i_ready  input  1  downstream accepts current output
- o_valid  output  1  o_bin/o_gray hold a valid sample
- o_bin  output  NBIT  registered binary count
- o_gray  output  NBIT  registered Gray code of o_bin, computed as o_bin ^ (o_bin >> 1)
- o_wrap  output  1  one-cycle pulse on modulo wrap
- o_err  output  1  sticky step-check error (see Configuration)

## Operation
- FSM states: IDLE and RUN. After reset the FSM is in IDLE, o_valid=0, and i_en is ignored.
- Priority within a cycle is i_load > i_stop > step.
- i_load, in any state: o_bin←i_load_val, o_gray←gray(i_load_val), o_valid←1, o_err←0, state←RUN.
- i_stop, without i_load: state←IDLE, o_valid←0. o_bin/o_gray keep their values.
- Step in RUN: occurs when o_valid && i_ready && i_en. Next count is o_bin±1 modulo 2^NBIT; o_gray updates in the same edge.
- RUN, no step: o_bin, o_gray, and o_valid hold. This covers both stall (i_ready=0) and pause (i_en=0).
- Wrap: o_wrap=1 for the cycle after a step from all-ones up to 0, or from 0 down to all-ones. Otherwise o_wrap=0.
- Direction may change on any step. Each step uses the i_up value sampled on that edge.
- o_bin and o_gray are always mutually consistent. Both come from flops, with no combinational path from inputs to outputs.

## Timing
- Reset values: o_bin=0, o_gray=0, o_valid=0, o_wrap=0, o_err=0, state IDLE.
- Reset is asynchronous and overrides all inputs. Asserting i_rstn=0 mid-RUN drops o_valid immediately.
- Load latency: 1 cycle. The loaded value appears on the edge that samples i_load.
- Step latency: 1 cycle. The handshake completes on edge N and the new value is visible after edge N.
- Throughput: one step per cycle while i_ready=1 and i_en=1.
- Handshake rule: while o_valid=1 and i_ready=0, outputs must not change, except through i_load, i_stop, or reset.
- i_load and i_stop asserted together behave exactly as i_load alone.

## Configuration
- GRAY_CNT_CHECK_EN defined:
  - A register holds the previous o_gray.
  - On every step, o_err is set if popcount(previous ^ new) ≠ 1.
  - o_err is sticky; only reset or i_load clears it.
- GRAY_CNT_CHECK_EN undefined:
  - No check logic is built.
  - o_err is tied to 0; the port remains.

## Test plan
- Reset then hold: i_rstn=0 for 20 cycles, then release with no load -> o_bin=0, o_gray=0, o_valid=0, o_wrap=0 throughout. Toggling i_en has no effect.
- Load and increment: i_load_val=0x7F, i_up=1, i_en=1, i_ready=1 -> 0x7F/gray 0x40, then 0x80/0xC0, then 0x81/0xC1 on consecutive cycles.
- Down wrap: load 0x01 with i_up=0 -> 0x00/0x00, then 0xFF/0x80 with o_wrap=1 for exactly that one cycle.
- Stall: in RUN at 0x0A, drop i_ready for 5 cycles -> outputs hold 0x0A/0x0F. On i_ready=1 the sequence continues 0x0B/0x0E.
- Priority and stop: assert i_load (0x06) and i_stop together -> RUN with 0x06/0x05 and o_valid=1. Next cycle i_stop -> o_valid=0 and the value is retained.
- Check feature, with GRAY_CNT_CHECK_EN: run a random-direction stream of 200 steps -> o_err stays 0. Assert i_rstn=0 mid-run -> all outputs return to reset values asynchronously.
